calc_seq_top: RTL and testbench

Second-generation calculator top for the DE2 board: signed add/sub/mul/div on two W-bit operands, with HEX display of result or operands and LED binary output. The ALU and bin2bcd stages are multi-cycle sequential engines behind a start/busy/done handshake. Results and display are registered and change only when a computation completes.

---
 rtl/calc_seq_top_pkg.sv | 45 ++++
 rtl/calc_seq_top_bin2bcd.sv | 50 +++++
 rtl/calc_seq_top.sv | 205 ++++++++++++++++++++
 tb/tb_calc_seq_top.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_top_pkg.sv
// Shared types and helpers for the sequential calculator: op codes, FSM states,
// display digit codes and the 7-segment decoder.
package calc_seq_top_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_CONV,
        S_DONE
    } state_t;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Decimal digits needed to show the magnitude of a signed value of 'bits' bits
    function automatic int dec_digits(input int bits);
        return (bits * 302) / 1000 + 1;
    endfunction

    // Active-high segments {g,f,e,d,c,b,a}; anything that is not a digit or minus is dark
    function automatic logic [6:0] bcd2seg(input logic [3:0] code);
        case (code)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/calc_seq_top_bin2bcd.sv
// Sequential double-dabble converter: the start cycle performs the first step,
// BITS-1 further steps follow, and the BCD result is held afterwards.
module seq_bin2bcd
    import calc_seq_top_pkg::*;
#(
    parameter int BITS   = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITS-1:0]       bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int CW = $clog2(BITS) + 1;

    logic [BITS-1:0] shreg;
    logic [CW-1:0]   remaining;

    function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] cur,
                                                   input logic in_bit);
        logic [4*DIGITS-1:0] adj;
        adj = cur;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[4*DIGITS-2:0], in_bit};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bcd       <= '0;
            remaining <= '0;
        end else if (start) begin
            bcd       <= dabble('0, bin[BITS-1]);
            shreg     <= bin << 1;
            remaining <= CW'(BITS - 1);
        end else if (remaining != '0) begin
            bcd       <= dabble(bcd, shreg[BITS-1]);
            shreg     <= shreg << 1;
            remaining <= remaining - 1'b1;
        end
    end

    // High when the BCD value will be complete after the coming edge
    assign done = !start && (remaining <= CW'(1));

endmodule

// File: rtl/calc_seq_top.sv
// Sequential signed calculator: iterative ALU, five parallel BCD converters and
// registered LED / 7-segment outputs that update only when a computation completes.
module calc_seq_top
    import calc_seq_top_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int N_SEGS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [2:0]            func,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    leds,
    output logic [7*N_SEGS-1:0]   segs,
    output logic                  err
);
    localparam int W2         = 2 * WIDTH;
    localparam int RES_DIGITS = dec_digits(W2);
    localparam int OP_DIGITS  = dec_digits(WIDTH);
    localparam int H          = N_SEGS / 2;
    localparam int CW         = $clog2(W2) + 1;

    state_t state, state_next;
    logic [CW-1:0] cnt;
    op_t op_lat;
    logic [WIDTH-1:0] a_lat, b_lat, quo, rem, q_val, r_val, quo_next, rem_next;
    logic [W2-1:0] acc, ma_sh, res_val, mul_next;
    logic [WIDTH-1:0] mb_sh, mag_b;
    logic [WIDTH:0] div_t;
    logic div_ge, calc_err, calc_last, conv_start;
    logic [4:0] conv_done;
    logic [4*RES_DIGITS-1:0] bcd_res;
    logic [4*OP_DIGITS-1:0] bcd_q, bcd_r, bcd_a, bcd_b;
    logic [4*N_SEGS-1:0] codes_res, codes_ops, codes_res_next, codes_ops_next, sel_codes;
    logic [W2-1:0] leds_res, leds_ops;

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [W2-1:0] mag_2w(input logic [W2-1:0] v);
        return v[W2-1] ? -v : v;
    endfunction

    assign calc_last = (op_lat == OP_ADD || op_lat == OP_SUB) ? (cnt == '0)
                                                              : (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (calc_last) state_next = S_CONV;
            S_CONV: if (&conv_done) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        conv_start = (state == S_CONV) && (cnt == '0);
    end

    // One shift-add or restoring-divide step per CALC cycle, both on magnitudes
    assign mag_b    = mag_w(b_lat);
    assign mul_next = acc + (mb_sh[0] ? ma_sh : '0);
    assign div_t    = {rem, quo[WIDTH-1]};
    assign div_ge   = div_t >= {1'b0, mag_b};
    assign quo_next = {quo[WIDTH-2:0], div_ge};
    assign rem_next = div_ge ? WIDTH'(div_t - {1'b0, mag_b}) : div_t[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat <= '0; b_lat <= '0; op_lat <= OP_ADD;
            acc <= '0; ma_sh <= '0; mb_sh <= '0; quo <= '0; rem <= '0;
            res_val <= '0; q_val <= '0; r_val <= '0; calc_err <= 1'b0;
            leds_res <= '0; leds_ops <= '0; err <= 1'b0; done <= 1'b0;
            codes_res <= {N_SEGS{DIG_BLANK}};
            codes_ops <= {N_SEGS{DIG_BLANK}};
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (start) begin
                    a_lat  <= a;
                    b_lat  <= b;
                    op_lat <= op_t'(func[1:0]);
                    acc    <= '0;
                    ma_sh  <= W2'(mag_w(a));
                    mb_sh  <= mag_w(b);
                    quo    <= mag_w(a);
                    rem    <= '0;
                end
                S_CALC: begin
                    case (op_lat)
                        OP_ADD: begin
                            res_val  <= {{WIDTH{a_lat[WIDTH-1]}}, a_lat} + {{WIDTH{b_lat[WIDTH-1]}}, b_lat};
                            calc_err <= 1'b0;
                        end
                        OP_SUB: begin
                            res_val  <= {{WIDTH{a_lat[WIDTH-1]}}, a_lat} - {{WIDTH{b_lat[WIDTH-1]}}, b_lat};
                            calc_err <= 1'b0;
                        end
                        OP_MUL: begin
                            acc   <= mul_next;
                            ma_sh <= ma_sh << 1;
                            mb_sh <= mb_sh >> 1;
                            if (calc_last) begin
                                res_val  <= (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) ? -mul_next : mul_next;
                                calc_err <= 1'b0;
                            end
                        end
                        OP_DIV: begin
                            quo <= quo_next;
                            rem <= rem_next;
                            if (calc_last) begin
                                if (mag_b == '0) begin
                                    q_val    <= '0;
                                    r_val    <= '0;
                                    calc_err <= 1'b1;
                                end else begin
                                    q_val    <= (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) ? -quo_next : quo_next;
                                    r_val    <= a_lat[WIDTH-1] ? -rem_next : rem_next;
                                    calc_err <= !(a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) && quo_next[WIDTH-1];
                                end
                            end
                        end
                    endcase
                end
                S_CONV: ;
                S_DONE: begin
                    leds_res  <= (op_lat == OP_DIV) ? {q_val, r_val} : res_val;
                    leds_ops  <= {a_lat, b_lat};
                    err       <= calc_err;
                    codes_res <= codes_res_next;
                    codes_ops <= codes_ops_next;
                end
            endcase
        end
    end

    seq_bin2bcd #(.BITS(W2), .DIGITS(RES_DIGITS)) u_res (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(mag_2w(res_val)),
        .bcd(bcd_res), .done(conv_done[0]));
    seq_bin2bcd #(.BITS(WIDTH), .DIGITS(OP_DIGITS)) u_q (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(mag_w(q_val)),
        .bcd(bcd_q), .done(conv_done[1]));
    seq_bin2bcd #(.BITS(WIDTH), .DIGITS(OP_DIGITS)) u_r (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(mag_w(r_val)),
        .bcd(bcd_r), .done(conv_done[2]));
    seq_bin2bcd #(.BITS(WIDTH), .DIGITS(OP_DIGITS)) u_a (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(mag_w(a_lat)),
        .bcd(bcd_a), .done(conv_done[3]));
    seq_bin2bcd #(.BITS(WIDTH), .DIGITS(OP_DIGITS)) u_b (
        .clk(clk), .rst_n(rst_n), .start(conv_start), .bin(mag_w(b_lat)),
        .bcd(bcd_b), .done(conv_done[4]));

    // Divide and operand views share a split layout: low half quotient/b, high half remainder/a
    always_comb begin
        codes_res_next = {N_SEGS{DIG_BLANK}};
        codes_ops_next = {N_SEGS{DIG_BLANK}};
        if (op_lat == OP_DIV) begin
            for (int i = 0; i < OP_DIGITS; i++) begin
                codes_res_next[4*i +: 4]     = bcd_q[4*i +: 4];
                codes_res_next[4*(H+i) +: 4] = bcd_r[4*i +: 4];
            end
            codes_res_next[4*OP_DIGITS +: 4]     = q_val[WIDTH-1] ? DIG_MINUS : DIG_BLANK;
            codes_res_next[4*(H+OP_DIGITS) +: 4] = r_val[WIDTH-1] ? DIG_MINUS : DIG_BLANK;
        end else begin
            for (int i = 0; i < RES_DIGITS; i++) begin
                codes_res_next[4*i +: 4] = bcd_res[4*i +: 4];
            end
            codes_res_next[4*RES_DIGITS +: 4] = res_val[W2-1] ? DIG_MINUS : DIG_BLANK;
        end
        for (int i = 0; i < OP_DIGITS; i++) begin
            codes_ops_next[4*i +: 4]     = bcd_b[4*i +: 4];
            codes_ops_next[4*(H+i) +: 4] = bcd_a[4*i +: 4];
        end
        codes_ops_next[4*OP_DIGITS +: 4]     = b_lat[WIDTH-1] ? DIG_MINUS : DIG_BLANK;
        codes_ops_next[4*(H+OP_DIGITS) +: 4] = a_lat[WIDTH-1] ? DIG_MINUS : DIG_BLANK;
    end

    assign leds = func[2] ? leds_ops : leds_res;

    always_comb begin
        sel_codes = func[2] ? codes_ops : codes_res;
        segs      = '1;
        for (int i = 0; i < N_SEGS; i++) begin
            segs[7*i +: 7] = ~bcd2seg(sel_codes[4*i +: 4]);
        end
    end

endmodule

// File: tb/tb_calc_seq_top.sv
// Self-checking bench for calc_seq_top: directed cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_calc_seq_top;
    localparam int WIDTH      = 6;
    localparam int N_SEGS     = 8;
    localparam int W2         = 2 * WIDTH;
    localparam int RES_DIGITS = (2 * WIDTH * 302) / 1000 + 1;
    localparam int OP_DIGITS  = (WIDTH * 302) / 1000 + 1;
    localparam int H          = N_SEGS / 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH-1:0]    a, b;
    logic [2:0]          func;
    logic                start;
    logic                busy, done, err;
    logic [W2-1:0]       leds;
    logic [7*N_SEGS-1:0] segs;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    logic [W2-1:0]       exp_leds_res, exp_leds_ops;
    logic                exp_err;
    logic [4*N_SEGS-1:0] exp_codes_res, exp_codes_ops;
    int                  exp_lat;

    calc_seq_top #(.WIDTH(WIDTH), .N_SEGS(N_SEGS)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .func(func), .start(start),
        .busy(busy), .done(done), .leds(leds), .segs(segs), .err(err));

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  4'hA: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7*N_SEGS-1:0] to_segs(input logic [4*N_SEGS-1:0] codes);
        logic [7*N_SEGS-1:0] s;
        for (int i = 0; i < N_SEGS; i++) s[7*i +: 7] = ~seg_of(codes[4*i +: 4]);
        return s;
    endfunction

    // Writes |val| as ndig decimal digits from position base, sign just above them
    function automatic logic [4*N_SEGS-1:0] place(input logic [4*N_SEGS-1:0] cur, input int val,
                                                  input int base, input int ndig);
        logic [4*N_SEGS-1:0] r;
        int m;
        r = cur;
        m = (val < 0) ? -val : val;
        for (int i = 0; i < ndig; i++) begin
            r[4*(base+i) +: 4] = 4'(m % 10);
            m = m / 10;
        end
        r[4*(base+ndig) +: 4] = (val < 0) ? 4'hA : 4'hF;
        return r;
    endfunction

    task automatic model(input logic [WIDTH-1:0] av6, input logic [WIDTH-1:0] bv6, input logic [1:0] op);
        int av, bv, r, q, rm;
        logic signed [WIDTH-1:0] qs;
        av = $signed(av6);
        bv = $signed(bv6);
        exp_err       = 1'b0;
        exp_codes_res = {N_SEGS{4'hF}};
        exp_lat       = (op[1] ? WIDTH : 1) + 2 * WIDTH + 1;
        if (op == 2'b11) begin
            if (bv == 0) begin
                q = 0; rm = 0; exp_err = 1'b1;
            end else begin
                q = av / bv; rm = av % bv;
                if (q > (1 << (WIDTH - 1)) - 1) exp_err = 1'b1;
            end
            qs = WIDTH'(q);
            exp_leds_res  = {WIDTH'(q), WIDTH'(rm)};
            exp_codes_res = place(place(exp_codes_res, int'(qs), 0, OP_DIGITS), rm, H, OP_DIGITS);
        end else begin
            r = (op == 2'b00) ? av + bv : (op == 2'b01) ? av - bv : av * bv;
            exp_leds_res  = W2'(r);
            exp_codes_res = place(exp_codes_res, r, 0, RES_DIGITS);
        end
        exp_leds_ops  = {av6, bv6};
        exp_codes_ops = place(place({N_SEGS{4'hF}}, bv, 0, OP_DIGITS), av, H, OP_DIGITS);
    endtask

    task automatic checkView(input string tag);
        if (func[2]) begin
            checkOutput({tag, ".leds_ops"}, leds, exp_leds_ops);
            checkOutput({tag, ".segs_ops"}, segs, to_segs(exp_codes_ops));
        end else begin
            checkOutput({tag, ".leds"}, leds, exp_leds_res);
            checkOutput({tag, ".segs"}, segs, to_segs(exp_codes_res));
        end
    endtask

    // Launch one op; poke=1 pulses start and scrambles inputs while busy
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [2:0] f, input bit poke);
        int cycles, dc0;
        bit seen;
        model(av, bv, f[1:0]);
        @(negedge clk);
        a = av; b = bv; func = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc0 = done_count; seen = 0; cycles = 0;
        while (!seen && cycles < 100) begin
            @(posedge clk);
            cycles++;
            if (poke && cycles == 3) begin
                #1 start = 1'b1; a = ~av; b = bv + 1'b1; func[1:0] = ~f[1:0];
            end
            if (poke && cycles == 6) begin
                #1 start = 1'b0; a = av; b = bv; func = f;
            end
            @(negedge clk);
            if (cycles == 1) checkOutput({tag, ".busy"}, busy, 1'b1);
            if (done) seen = 1;
        end
        checkOutput({tag, ".latency"}, cycles, exp_lat);
        checkOutput({tag, ".busy_end"}, busy, 1'b0);
        checkOutput({tag, ".err"}, err, exp_err);
        checkView(tag);
        if (poke) begin
            repeat (25) @(negedge clk);
            checkOutput({tag, ".ndone"}, done_count - dc0, 1);
        end
    endtask

    initial begin
        int dc0, cycles, first, second;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; func = 3'b000;
        #12;
        checkOutput("rst.busy", busy, 1'b0);
        checkOutput("rst.done", done, 1'b0);
        checkOutput("rst.err", err, 1'b0);
        checkOutput("rst.leds", leds, '0);
        checkOutput("rst.segs", segs, {7*N_SEGS{1'b1}});
        rst_n = 1'b1;

        applyStimulus("add", 6'd12, 6'h2C, 3'b000, 0);
        checkOutput("add.const", leds, 12'hFF8);
        applyStimulus("mul", 6'h3B, 6'd7, 3'b010, 0);
        checkOutput("mul.const", leds, 12'hFDD);
        applyStimulus("div", 6'd7, 6'h3E, 3'b011, 1);
        checkOutput("div.const", leds, {6'h3D, 6'h01});
        #1 func[2] = 1'b1;
        #1 checkView("div.ops");
        checkOutput("div.ops.const", leds, 12'h1FE);
        func[2] = 1'b0;
        #1 checkView("div.back");

        applyStimulus("div0", 6'd5, 6'd0, 3'b011, 0);
        applyStimulus("divovf", 6'h20, 6'h3F, 3'b011, 0);
        applyStimulus("add34", 6'd3, 6'd4, 3'b000, 0);
        applyStimulus("mulmin", 6'h20, 6'h20, 3'b010, 0);
        applyStimulus("sub", 6'h20, 6'd31, 3'b101, 0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("rnd", WIDTH'($urandom), WIDTH'($urandom), 3'($urandom), 0);
            #1 func[2] = ~func[2];
            #1 checkView("rnd.tog");
        end

        // start held high: second op accepted in the cycle right after done
        @(negedge clk);
        a = 6'd3; b = 6'd4; func = 3'b000; start = 1'b1;
        @(posedge clk);
        cycles = 0; first = 0; second = 0;
        while (second == 0 && cycles < 80) begin
            @(posedge clk);
            cycles++;
            if (first != 0) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                if (first == 0) first = cycles;
                else second = cycles;
            end
        end
        start = 1'b0;
        checkOutput("b2b.first", first, 1 + 2 * WIDTH + 1);
        checkOutput("b2b.second", second, 2 * (1 + 2 * WIDTH + 1) + 1);

        // Reset in the middle of a multiply aborts it
        @(negedge clk);
        a = 6'd9; b = 6'h3D; func = 3'b010; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        dc0 = done_count;
        #1;
        checkOutput("rstmid.busy", busy, 1'b0);
        checkOutput("rstmid.done", done, 1'b0);
        checkOutput("rstmid.leds", leds, '0);
        checkOutput("rstmid.segs", segs, {7*N_SEGS{1'b1}});
        checkOutput("rstmid.err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("rstmid.nodone", done_count - dc0, 0);
        checkOutput("rstmid.idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
